// File: rtl/divisor_seq.sv
// Sequential unsigned restoring divider: one shift and one conditional subtract per quotient bit.
// Define DIV_ZERO_DETECT_EN to short-circuit a zero divisor straight to DONE and flag div_by_zero.
module divisor_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [N:0]    a_reg, a_next;
    logic [N-1:0]  q_reg, q_next;
    logic [N-1:0]  b_reg, b_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [N:0]    diff;

    // A borrow out of the top bit means the divisor did not fit: keep A (restore).
    assign diff = a_reg - {1'b0, b_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            q_reg     <= q_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        q_next     = q_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    q_next     = dividend;
                    b_next     = divisor;
                    state_next = S_INIT;
                end
            end
            S_INIT: begin
                a_next     = '0;
                cnt_next   = CW'(N);
                state_next = S_SHIFT;
`ifdef DIV_ZERO_DETECT_EN
                if (b_reg == '0) begin
                    a_next     = {1'b0, q_reg};
                    q_next     = '1;
                    state_next = S_DONE;
                end
`endif
            end
            S_SHIFT: begin
                {a_next, q_next} = {a_reg, q_reg} << 1;
                cnt_next         = cnt_reg - CW'(1);
                state_next       = S_SUB;
            end
            S_SUB: begin
                if (!diff[N]) begin
                    a_next = diff;
                    q_next = {q_reg[N-1:1], 1'b1};
                end
                state_next = (cnt_reg == '0) ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                if (!start) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign quotient  = q_reg;
    assign remainder = a_reg[N-1:0];
    assign busy      = (state_reg == S_INIT) || (state_reg == S_SHIFT) || (state_reg == S_SUB);
    assign done      = (state_reg == S_DONE);

`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = (state_reg == S_DONE) && (b_reg == '0);
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_seq.sv
// Directed bench for divisor_seq (N=8): latency, results, handshake, reset and input-hold behaviour.
module tb_divisor_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;
    int lat;

`ifdef DIV_ZERO_DETECT_EN
    localparam int  ZLAT = 2;
    localparam logic ZFLAG = 1'b1;
`else
    localparam int  ZLAT = 18;
    localparam logic ZFLAG = 1'b0;
`endif

    divisor_seq #(.N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Starts an op from IDLE and counts edges until done (bounded).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit hold_start, input bit scramble, output int n);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        n        = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("busy_edge1", 32'(busy), 32'd1);
            if (!hold_start) start = 1'b0;
            if (scramble) begin
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
        end while (done !== 1'b1 && n < 100);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 100/7 with a one-cycle start pulse
        run_op(8'd100, 8'd7, 1'b0, 1'b0, lat);
        chk("lat_100_7", 32'(lat), 32'd18);
        chk("q_100_7", 32'(quotient), 32'd14);
        chk("r_100_7", 32'(remainder), 32'd2);
        chk("dbz_100_7", 32'(div_by_zero), 32'd0);
        @(posedge clk); #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // 255/1 then 5/9 back-to-back, start held until done
        run_op(8'd255, 8'd1, 1'b1, 1'b0, lat);
        chk("lat_255_1", 32'(lat), 32'd18);
        chk("q_255_1", 32'(quotient), 32'd255);
        chk("r_255_1", 32'(remainder), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle", 32'(done), 32'd0);
        run_op(8'd5, 8'd9, 1'b1, 1'b0, lat);
        chk("lat_5_9", 32'(lat), 32'd18);
        chk("q_5_9", 32'(quotient), 32'd0);
        chk("r_5_9", 32'(remainder), 32'd5);
        start = 1'b0;
        @(posedge clk); #1;

        // divide by zero
        run_op(8'd37, 8'd0, 1'b0, 1'b0, lat);
        chk("lat_37_0", 32'(lat), 32'(ZLAT));
        chk("q_37_0", 32'(quotient), 32'd255);
        chk("r_37_0", 32'(remainder), 32'd37);
        chk("dbz_37_0", 32'(div_by_zero), 32'(ZFLAG));
        @(posedge clk); #1;
        chk("dbz_clear", 32'(div_by_zero), 32'd0);

        // start held 5 cycles past done: stay in DONE, then drop
        run_op(8'd50, 8'd6, 1'b1, 1'b0, lat);
        chk("lat_50_6", 32'(lat), 32'd18);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_q", 32'(quotient), 32'd8);
            chk("hold_r", 32'(remainder), 32'd2);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("drop_done", 32'(done), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("no_restart", 32'(busy), 32'd0);

        // reset asserted so that edge 7 of 200/3 sees it
        dividend = 8'd200; divisor = 8'd3; start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_q", 32'(quotient), 32'd0);
        chk("mrst_r", 32'(remainder), 32'd0);
        chk("mrst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(8'd200, 8'd3, 1'b0, 1'b0, lat);
        chk("lat_200_3", 32'(lat), 32'd18);
        chk("q_200_3", 32'(quotient), 32'd66);
        chk("r_200_3", 32'(remainder), 32'd2);
        @(posedge clk); #1;

        // inputs scrambled every cycle after the sampling edge
        run_op(8'd123, 8'd10, 1'b0, 1'b1, lat);
        chk("lat_123_10", 32'(lat), 32'd18);
        chk("q_123_10", 32'(quotient), 32'd12);
        chk("r_123_10", 32'(remainder), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
